// File: rtl/counter_nbits_if.sv
// Control and status bundle for one counter_nbits stage.
// The bench drives the master side, and the counter owns the slave side.
interface counter_nbits_if #(
  parameter int WIDTH = 32
);
  logic             cnt_enable;
  logic             cnt_cin;
  logic [1:0]       cnt_mode;
  logic [WIDTH-1:0] cnt_D;
  logic [WIDTH-1:0] cnt_Q;
  logic             cnt_rco;
  logic             cnt_load;
  logic             cnt_ovf;
  logic             cnt_tc;

  modport master (
    output cnt_enable, cnt_cin, cnt_mode, cnt_D,
    input  cnt_Q, cnt_rco, cnt_load, cnt_ovf, cnt_tc
  );

  modport slave (
    input  cnt_enable, cnt_cin, cnt_mode, cnt_D,
    output cnt_Q, cnt_rco, cnt_load, cnt_ovf, cnt_tc
  );
endinterface

// File: rtl/counter_nbits.sv
// WIDTH-bit up/down/step/load counter with a wrap or saturate policy and a sticky overflow flag.
// The combinational cnt_tc output feeds the next stage's cnt_cin so that narrow stages cascade.
module counter_nbits #(
  parameter int WIDTH    = 32,
  parameter int STEP     = 3,
  parameter bit SATURATE = 1'b0
) (
  input logic            cnt_clk,
  input logic            cnt_reset,
  counter_nbits_if.slave bus
);

  localparam logic [1:0]       MODE_UP   = 2'b00;
  localparam logic [1:0]       MODE_DN   = 2'b01;
  localparam logic [1:0]       MODE_STEP = 2'b10;
  localparam logic [1:0]       MODE_LOAD = 2'b11;
  localparam logic [WIDTH-1:0] Q_MAX     = '1;
  localparam logic [WIDTH-1:0] Q_ONE     = WIDTH'(1);
  localparam logic [WIDTH:0]   STEP_W    = (WIDTH+1)'(STEP);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic             rco_r;
  logic             load_r;
  logic             ovf_r;
  logic             active;
  logic             evt;
  logic [WIDTH:0]   step_diff;

  assign active    = bus.cnt_enable & bus.cnt_cin;
  // The extra top bit is the borrow, so it is set exactly when Q < STEP.
  assign step_diff = {1'b0, q_r} - STEP_W;

  always_comb begin
    evt   = 1'b0;
    q_nxt = q_r;
    case (bus.cnt_mode)
      MODE_UP: begin
        evt   = (q_r == Q_MAX);
        q_nxt = (evt && SATURATE) ? Q_MAX : q_r + Q_ONE;
      end
      MODE_DN: begin
        evt   = (q_r == '0);
        q_nxt = (evt && SATURATE) ? '0 : q_r - Q_ONE;
      end
      MODE_STEP: begin
        evt   = step_diff[WIDTH];
        q_nxt = (evt && SATURATE) ? '0 : step_diff[WIDTH-1:0];
      end
      default: begin
        evt   = 1'b0;
        q_nxt = bus.cnt_D;
      end
    endcase
  end

  // A load needs only the enable, so that a whole chain can load in parallel.
  always_ff @(posedge cnt_clk) begin
    if (cnt_reset) begin
      q_r    <= '0;
      rco_r  <= 1'b0;
      load_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (bus.cnt_enable && (bus.cnt_mode == MODE_LOAD)) begin
      q_r    <= bus.cnt_D;
      rco_r  <= 1'b0;
      load_r <= 1'b1;
      ovf_r  <= 1'b0;
    end else if (active) begin
      q_r    <= q_nxt;
      rco_r  <= evt;
      load_r <= 1'b0;
      ovf_r  <= ovf_r | evt;
    end else begin
      rco_r  <= 1'b0;
      load_r <= 1'b0;
    end
  end

  assign bus.cnt_Q    = q_r;
  assign bus.cnt_rco  = rco_r;
  assign bus.cnt_load = load_r;
  assign bus.cnt_ovf  = ovf_r;
  assign bus.cnt_tc   = active & (bus.cnt_mode != MODE_LOAD) & evt;

endmodule

// File: tb/tb_counter_nbits.sv
// Bench for counter_nbits: directed scenarios plus random stimulus that is checked
// against an integer-arithmetic model, covering 4-bit wrap, saturate and chained 8-bit builds.
`timescale 1ns/1ps
module tb_counter_nbits;

  typedef struct {
    int q;
    bit rco;
    bit load;
    bit ovf;
  } st_t;

  logic       cnt_clk   = 1'b0;
  logic       cnt_reset = 1'b0;
  logic [7:0] chain_d   = '0;
  int         n_cmp     = 0;
  int         n_bad     = 0;

  always #5 cnt_clk = ~cnt_clk;

  counter_nbits_if #(.WIDTH(4)) w_if ();
  counter_nbits_if #(.WIDTH(4)) s_if ();
  counter_nbits_if #(.WIDTH(4)) lo_if ();
  counter_nbits_if #(.WIDTH(4)) hi_if ();

  counter_nbits #(.WIDTH(4), .STEP(3), .SATURATE(1'b0)) u_wrap (
    .cnt_clk(cnt_clk), .cnt_reset(cnt_reset), .bus(w_if.slave));
  counter_nbits #(.WIDTH(4), .STEP(3), .SATURATE(1'b1)) u_sat (
    .cnt_clk(cnt_clk), .cnt_reset(cnt_reset), .bus(s_if.slave));
  counter_nbits #(.WIDTH(4), .STEP(3), .SATURATE(1'b0)) u_lo (
    .cnt_clk(cnt_clk), .cnt_reset(cnt_reset), .bus(lo_if.slave));
  // The upper stage takes one borrow from the lower stage, so its own step is 1.
  counter_nbits #(.WIDTH(4), .STEP(1), .SATURATE(1'b0)) u_hi (
    .cnt_clk(cnt_clk), .cnt_reset(cnt_reset), .bus(hi_if.slave));

  assign lo_if.cnt_D      = chain_d[3:0];
  assign hi_if.cnt_D      = chain_d[7:4];
  assign hi_if.cnt_enable = lo_if.cnt_enable;
  assign hi_if.cnt_mode   = lo_if.cnt_mode;
  assign hi_if.cnt_cin    = lo_if.cnt_tc;

  function automatic int raw_next(int q, logic [1:0] mode, int step);
    case (mode)
      2'b00:   return q + 1;
      2'b01:   return q - 1;
      default: return q - step;
    endcase
  endfunction

  function automatic st_t model(st_t s, bit rst, bit en, bit cin, logic [1:0] mode,
                                int d, int step, bit sat);
    st_t r;
    int  nq;
    r = s;
    if (rst) begin
      r = '{q: 0, rco: 1'b0, load: 1'b0, ovf: 1'b0};
    end else if (en && mode == 2'b11) begin
      r = '{q: d, rco: 1'b0, load: 1'b1, ovf: 1'b0};
    end else if (en && cin) begin
      nq     = raw_next(s.q, mode, step);
      r.load = 1'b0;
      if (nq < 0 || nq > 15) begin
        r.rco = 1'b1;
        r.ovf = 1'b1;
        r.q   = sat ? ((nq < 0) ? 0 : 15) : (nq + 16) % 16;
      end else begin
        r.rco = 1'b0;
        r.q   = nq;
      end
    end else begin
      r.rco  = 1'b0;
      r.load = 1'b0;
    end
    return r;
  endfunction

  function automatic bit model_tc(st_t s, bit en, bit cin, logic [1:0] mode, int step);
    int nq;
    nq = raw_next(s.q, mode, step);
    return en && cin && (mode != 2'b11) && (nq < 0 || nq > 15);
  endfunction

  function automatic logic [6:0] pk(st_t s);
    return {s.q[3:0], s.rco, s.load, s.ovf};
  endfunction

  function automatic logic [6:0] obs_w();
    return {w_if.cnt_Q, w_if.cnt_rco, w_if.cnt_load, w_if.cnt_ovf};
  endfunction

  function automatic logic [6:0] obs_s();
    return {s_if.cnt_Q, s_if.cnt_rco, s_if.cnt_load, s_if.cnt_ovf};
  endfunction

  task automatic tick();
    @(posedge cnt_clk);
    #1;
  endtask

  task automatic drive_w(bit en, bit cin, logic [1:0] mode, logic [3:0] d);
    w_if.cnt_enable = en;
    w_if.cnt_cin    = cin;
    w_if.cnt_mode   = mode;
    w_if.cnt_D      = d;
  endtask

  task automatic drive_s(bit en, bit cin, logic [1:0] mode, logic [3:0] d);
    s_if.cnt_enable = en;
    s_if.cnt_cin    = cin;
    s_if.cnt_mode   = mode;
    s_if.cnt_D      = d;
  endtask

  task automatic drive_c(bit en, logic [1:0] mode, logic [7:0] d);
    lo_if.cnt_enable = en;
    lo_if.cnt_cin    = 1'b1;
    lo_if.cnt_mode   = mode;
    chain_d          = d;
  endtask

  task automatic test_reset();
    drive_w(1'b0, 1'b1, 2'b00, 4'h0);
    drive_s(1'b0, 1'b1, 2'b00, 4'h0);
    drive_c(1'b0, 2'b00, 8'h00);
    cnt_reset = 1'b1;
    tick();
    cnt_reset = 1'b0;
    n_cmp++; if (obs_w() !== 7'h00) begin n_bad++; $display("FAIL reset_wrap: got %h want 00", obs_w()); end
    n_cmp++; if (obs_s() !== 7'h00) begin n_bad++; $display("FAIL reset_sat: got %h want 00", obs_s()); end
    drive_w(1'b1, 1'b1, 2'b11, 4'h9);
    tick();
    drive_w(1'b1, 1'b1, 2'b00, 4'h0);
    cnt_reset = 1'b1;
    tick();
    cnt_reset = 1'b0;
    n_cmp++; if (obs_w() !== 7'h00) begin n_bad++; $display("FAIL reset_midcount: got %h want 00", obs_w()); end
    tick();
    n_cmp++; if (obs_w() !== {4'h1, 3'b000}) begin n_bad++; $display("FAIL reset_resume1: got %h want %h", obs_w(), {4'h1, 3'b000}); end
    tick();
    n_cmp++; if (obs_w() !== {4'h2, 3'b000}) begin n_bad++; $display("FAIL reset_resume2: got %h want %h", obs_w(), {4'h2, 3'b000}); end
    drive_w(1'b1, 1'b1, 2'b11, 4'h5);
    cnt_reset = 1'b1;
    tick();
    cnt_reset = 1'b0;
    n_cmp++; if (obs_w() !== 7'h00) begin n_bad++; $display("FAIL reset_midload: got %h want 00", obs_w()); end
  endtask

  task automatic test_load_up();
    logic [1:0] md [5] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b11};
    logic [3:0] dd [5] = '{4'hE, 4'h0, 4'h0, 4'h0, 4'h3};
    bit         tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [6:0] ex [5] = '{{4'hE, 3'b010}, {4'hF, 3'b000}, {4'h0, 3'b101},
                           {4'h1, 3'b001}, {4'h3, 3'b010}};
    for (int i = 0; i < 5; i++) begin
      drive_w(1'b1, 1'b1, md[i], dd[i]);
      #1;
      n_cmp++; if (w_if.cnt_tc !== tc[i]) begin n_bad++; $display("FAIL load_up_tc step %0d: got %b want %b", i, w_if.cnt_tc, tc[i]); end
      tick();
      n_cmp++; if (obs_w() !== ex[i]) begin n_bad++; $display("FAIL load_up step %0d: got %h want %h", i, obs_w(), ex[i]); end
    end
  endtask

  task automatic test_step_down();
    logic [1:0] md [7] = '{2'b11, 2'b10, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [3:0] dd [7] = '{4'h2, 4'h0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0};
    bit         tc [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [6:0] ex [7] = '{{4'h2, 3'b010}, {4'hF, 3'b101}, {4'h9, 3'b010}, {4'h6, 3'b000},
                           {4'h3, 3'b000}, {4'h0, 3'b000}, {4'hD, 3'b101}};
    for (int i = 0; i < 7; i++) begin
      drive_w(1'b1, 1'b1, md[i], dd[i]);
      #1;
      n_cmp++; if (w_if.cnt_tc !== tc[i]) begin n_bad++; $display("FAIL step_down_tc step %0d: got %b want %b", i, w_if.cnt_tc, tc[i]); end
      tick();
      n_cmp++; if (obs_w() !== ex[i]) begin n_bad++; $display("FAIL step_down step %0d: got %h want %h", i, obs_w(), ex[i]); end
    end
  endtask

  task automatic test_saturate();
    logic [1:0] md [10] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b11, 2'b10, 2'b10, 2'b01};
    logic [3:0] dd [10] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
    bit         tc [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [6:0] ex [10] = '{{4'hF, 3'b010}, {4'hF, 3'b101}, {4'hF, 3'b101}, {4'hF, 3'b101},
                            {4'h0, 3'b010}, {4'h0, 3'b101}, {4'h1, 3'b010}, {4'h0, 3'b101},
                            {4'h0, 3'b101}, {4'h0, 3'b101}};
    for (int i = 0; i < 10; i++) begin
      drive_s(1'b1, 1'b1, md[i], dd[i]);
      #1;
      n_cmp++; if (s_if.cnt_tc !== tc[i]) begin n_bad++; $display("FAIL saturate_tc step %0d: got %b want %b", i, s_if.cnt_tc, tc[i]); end
      tick();
      n_cmp++; if (obs_s() !== ex[i]) begin n_bad++; $display("FAIL saturate step %0d: got %h want %h", i, obs_s(), ex[i]); end
    end
  endtask

  task automatic test_inactive();
    bit         en [11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    bit         ci [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0] md [11] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b11, 2'b00, 2'b11};
    logic [3:0] dd [11] = '{4'h7, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'hA};
    logic [6:0] ex [11] = '{{4'h7, 3'b010}, {4'h7, 3'b000}, {4'h7, 3'b000}, {4'h7, 3'b000},
                            {4'h7, 3'b000}, {4'h7, 3'b000}, {4'h7, 3'b000}, {4'h7, 3'b000},
                            {4'hF, 3'b010}, {4'hF, 3'b000}, {4'hA, 3'b010}};
    for (int i = 0; i < 11; i++) begin
      drive_w(en[i], ci[i], md[i], dd[i]);
      #1;
      n_cmp++; if (w_if.cnt_tc !== 1'b0) begin n_bad++; $display("FAIL inactive_tc step %0d: got %b want 0", i, w_if.cnt_tc); end
      tick();
      n_cmp++; if (obs_w() !== ex[i]) begin n_bad++; $display("FAIL inactive step %0d: got %h want %h", i, obs_w(), ex[i]); end
    end
  endtask

  task automatic test_chain();
    logic [1:0] md [6] = '{2'b11, 2'b00, 2'b11, 2'b01, 2'b11, 2'b10};
    logic [7:0] dd [6] = '{8'h0F, 8'h00, 8'h00, 8'h00, 8'h12, 8'h00};
    bit         tc [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] ex [6] = '{8'h0F, 8'h10, 8'h00, 8'hFF, 8'h12, 8'h0F};
    for (int i = 0; i < 6; i++) begin
      drive_c(1'b1, md[i], dd[i]);
      #1;
      n_cmp++; if (lo_if.cnt_tc !== tc[i]) begin n_bad++; $display("FAIL chain_tc step %0d: got %b want %b", i, lo_if.cnt_tc, tc[i]); end
      tick();
      n_cmp++; if ({hi_if.cnt_Q, lo_if.cnt_Q} !== ex[i]) begin n_bad++; $display("FAIL chain step %0d: got %h want %h", i, {hi_if.cnt_Q, lo_if.cnt_Q}, ex[i]); end
    end
  endtask

  task automatic test_random();
    st_t        mw, ms;
    int         cv;
    bit         rst, en_w, ci_w, en_s, ci_s, en_c, tcw, tcs;
    logic [1:0] m_w, m_s, m_c;
    logic [3:0] d_w, d_s;
    logic [7:0] d_c;
    mw = '{q: 0, rco: 1'b0, load: 1'b0, ovf: 1'b0};
    ms = mw;
    cv = 0;
    for (int i = 0; i < 400; i++) begin
      rst  = (i == 0) || ($urandom_range(0, 39) == 0);
      en_w = ($urandom_range(0, 7) != 0);
      ci_w = ($urandom_range(0, 5) != 0);
      en_s = ($urandom_range(0, 7) != 0);
      ci_s = ($urandom_range(0, 5) != 0);
      en_c = ($urandom_range(0, 7) != 0);
      m_w  = 2'($urandom_range(0, 3));
      m_s  = 2'($urandom_range(0, 3));
      m_c  = 2'($urandom_range(0, 3));
      d_w  = 4'($urandom);
      d_s  = 4'($urandom);
      d_c  = 8'($urandom);
      cnt_reset = rst;
      drive_w(en_w, ci_w, m_w, d_w);
      drive_s(en_s, ci_s, m_s, d_s);
      drive_c(en_c, m_c, d_c);
      #1;
      tcw = model_tc(mw, en_w, ci_w, m_w, 3);
      tcs = model_tc(ms, en_s, ci_s, m_s, 3);
      n_cmp++; if (w_if.cnt_tc !== tcw) begin n_bad++; $display("FAIL rand_tc_wrap cycle %0d: got %b want %b", i, w_if.cnt_tc, tcw); end
      n_cmp++; if (s_if.cnt_tc !== tcs) begin n_bad++; $display("FAIL rand_tc_sat cycle %0d: got %b want %b", i, s_if.cnt_tc, tcs); end
      tick();
      mw = model(mw, rst, en_w, ci_w, m_w, int'(d_w), 3, 1'b0);
      ms = model(ms, rst, en_s, ci_s, m_s, int'(d_s), 3, 1'b1);
      if (rst) cv = 0;
      else if (en_c) begin
        case (m_c)
          2'b00:   cv = (cv + 1) % 256;
          2'b01:   cv = (cv + 255) % 256;
          2'b10:   cv = (cv + 253) % 256;
          default: cv = int'(d_c);
        endcase
      end
      n_cmp++; if (obs_w() !== pk(mw)) begin n_bad++; $display("FAIL rand_wrap cycle %0d: got %h want %h", i, obs_w(), pk(mw)); end
      n_cmp++; if (obs_s() !== pk(ms)) begin n_bad++; $display("FAIL rand_sat cycle %0d: got %h want %h", i, obs_s(), pk(ms)); end
      n_cmp++; if ({hi_if.cnt_Q, lo_if.cnt_Q} !== 8'(cv)) begin n_bad++; $display("FAIL rand_chain cycle %0d: got %h want %h", i, {hi_if.cnt_Q, lo_if.cnt_Q}, 8'(cv)); end
    end
    cnt_reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_up();
    test_step_down();
    test_saturate();
    test_inactive();
    test_chain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
